// File: rtl/game_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | game_pkg : shared direction/key codes and default timing         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package game_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        KEY_NONE  = 2'b00,
        KEY_LEFT  = 2'b01,
        KEY_RIGHT = 2'b10
    } key_t;

    localparam int c_debounce_cycles = 1_300_000;
    localparam int c_repeat_delay    = 32_500_000;
    localparam int c_repeat_period   = 9_750_000;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | debouncer : 2-flop synchronizer plus stable-level debouncer      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module debouncer
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int                 c_cnt_w    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync0;
    logic               r_sync1;
    logic               r_stable;
    logic               r_level;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    // level and press are re-registered together so they stay cycle-aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_stable <= 1'b0;
            r_level  <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync0 <= btn;
            r_sync1 <= r_sync0;
            if (r_sync1 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level <= r_stable;
            r_press <= r_stable & ~r_level;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/player_input.sv
`default_nettype none
// +------------------------------------------------------------------+
// | player_input : buttons -> shield direction, menu keys, confirm   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module player_input
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles,
    parameter int REPEAT_DELAY    = c_repeat_delay,
    parameter int REPEAT_PERIOD   = c_repeat_period
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_center,
    output logic [1:0] rotate_out,
    output logic [1:0] key_out,
    output logic       decide_out
);

    localparam int c_up     = 0;
    localparam int c_right  = 1;
    localparam int c_down   = 2;
    localparam int c_left   = 3;
    localparam int c_center = 4;

    localparam int                 c_rep_w      = cnt_width(REPEAT_DELAY + REPEAT_PERIOD);
    localparam logic [c_rep_w-1:0] c_rep_first  = c_rep_w'(REPEAT_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_rep_next   = c_rep_w'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam logic [c_rep_w-1:0] c_rep_reload = c_rep_w'(REPEAT_DELAY);

    logic [4:0] w_btn;
    logic [4:0] w_level;
    logic [4:0] w_press;
    logic       w_one_held;
    logic       w_unused_levels;
    key_t       w_held_key;

    dir_t               r_rot;
    key_t               r_key;
    logic               r_decide;
    logic [c_rep_w-1:0] r_rep;

    assign w_btn = {btn_center, btn_left, btn_down, btn_right, btn_up};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk  (clk),
                .rst  (rst),
                .btn  (w_btn[gi]),
                .level(w_level[gi]),
                .press(w_press[gi])
            );
        end
    endgenerate

    assign w_one_held      = w_level[c_left] ^ w_level[c_right];
    assign w_held_key      = w_level[c_left] ? KEY_LEFT : KEY_RIGHT;
    assign w_unused_levels = ^{w_level[c_up], w_level[c_down], w_level[c_center]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rot    <= DIR_UP;
            r_key    <= KEY_NONE;
            r_decide <= 1'b0;
            r_rep    <= '0;
        end else begin
            if (w_press[c_up])
                r_rot <= DIR_UP;
            else if (w_press[c_right])
                r_rot <= DIR_RIGHT;
            else if (w_press[c_down])
                r_rot <= DIR_DOWN;
            else if (w_press[c_left])
                r_rot <= DIR_LEFT;

            r_decide <= w_press[c_center];

            // a press against the opposite held key falls through to the clear branch
            r_key <= KEY_NONE;
            if (w_press[c_left] && !w_level[c_right]) begin
                r_key <= KEY_LEFT;
                r_rep <= '0;
            end else if (w_press[c_right] && !w_level[c_left]) begin
                r_key <= KEY_RIGHT;
                r_rep <= '0;
            end else if (!w_one_held) begin
                r_rep <= '0;
            end else if (r_rep == c_rep_next) begin
                r_key <= w_held_key;
                r_rep <= c_rep_reload;
            end else begin
                if (r_rep == c_rep_first)
                    r_key <= w_held_key;
                r_rep <= r_rep + 1'b1;
            end
        end
    end

    assign rotate_out = r_rot;
    assign key_out    = r_key;
    assign decide_out = r_decide;

endmodule
`default_nettype wire
